// File: rtl/alu_arbiter_ctrl_pkg.sv
// Shared definitions for the two-port ALU arbiter: function codes, FSM states
// and the 4-bit ripple adder that the ALU core reuses.
package alu_arbiter_ctrl_pkg;

  localparam logic [2:0] FUN_INC    = 3'd0;
  localparam logic [2:0] FUN_ADD_RC = 3'd1;
  localparam logic [2:0] FUN_ADD    = 3'd2;
  localparam logic [2:0] FUN_ORXOR  = 3'd3;
  localparam logic [2:0] FUN_ORRED  = 3'd4;
  localparam logic [2:0] FUN_SHL    = 3'd5;
  localparam logic [2:0] FUN_SHR    = 3'd6;
  localparam logic [2:0] FUN_MUL    = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Bit-level ripple-carry adder; the carry out lands in bit 4.
  function automatic logic [4:0] ripple_add4(input logic [3:0] a,
                                             input logic [3:0] b,
                                             input logic       cin);
    logic [4:0] c;
    logic [3:0] s;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    return {c[4], s};
  endfunction

endpackage

// File: rtl/alu_arbiter_ctrl_if.sv
// Request/response bundle between the two operand sources, the arbiter and
// the result consumer. master = sources/consumer side, slave = arbiter side.
interface alu_arbiter_ctrl_if;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req_a0;
  logic [3:0] req_b0;
  logic [2:0] req_fun0;
  logic [3:0] req_a1;
  logic [3:0] req_b1;
  logic [2:0] req_fun1;
  logic [1:0] req_chain;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_id;

  modport master (
    output req_valid, req_a0, req_b0, req_fun0, req_a1, req_b1, req_fun1,
           req_chain, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_fun0, req_a1, req_b1, req_fun1,
           req_chain, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/alu_arbiter_ctrl_alu8_core.sv
// Combinational 8-function ALU on 4-bit operands with an 8-bit unsigned result.
module alu8_core
  import alu_arbiter_ctrl_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] fun,
  output logic [7:0] out
);

  logic [4:0] rc_sum;
  logic [4:0] inc_sum;

  assign rc_sum  = ripple_add4(a, b, 1'b0);
  assign inc_sum = ripple_add4(a, 4'd1, 1'b0);

  // Function select; every result is zero-extended to 8 bits.
  // NOTE: out gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    out = 8'h00;
    case (fun)
      FUN_INC:    out = {3'b000, inc_sum};
      FUN_ADD_RC: out = {3'b000, rc_sum};
      FUN_ADD:    out = {4'h0, a} + {4'h0, b};
      FUN_ORXOR:  out = {a | b, a ^ b};
      FUN_ORRED:  out = {7'b0, |{a, b}};
      FUN_SHL:    out = {4'h0, b} << a;
      FUN_SHR:    out = {4'h0, b} >> a;
      FUN_MUL:    out = {4'h0, a} * {4'h0, b};
      default:    out = 8'h00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter_ctrl.sv
// Round-robin arbiter sharing one ALU between two requesters: capture the
// granted operands, execute for one cycle, hold the tagged result until taken.
module alu_arbiter_ctrl
  import alu_arbiter_ctrl_pkg::*;
#(
  parameter bit CHAIN_EN = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  alu_arbiter_ctrl_if.slave        bus,
  output logic                     busy,
  output logic [7:0]               last_result
);

  state_t     state, state_next;
  logic       ptr;
  logic       grant;
  logic       accept;
  logic [1:0] ready;

  logic [3:0] sel_a, sel_b, sel_b_raw;
  logic [2:0] sel_fun;
  logic       sel_chain;

  logic [3:0] op_a, op_b;
  logic [2:0] op_fun;
  logic       op_id;

  logic [7:0] alu_out;
  logic [7:0] rsp_data_q;
  logic       rsp_id_q;
  logic [7:0] last_result_q;

  // Grant: a lone valid port wins; on contention the pointer decides.
  always_comb begin
    grant = ptr;
    if (bus.req_valid == 2'b01)      grant = 1'b0;
    else if (bus.req_valid == 2'b10) grant = 1'b1;
  end

  assign sel_a     = grant ? bus.req_a1   : bus.req_a0;
  assign sel_b_raw = grant ? bus.req_b1   : bus.req_b0;
  assign sel_fun   = grant ? bus.req_fun1 : bus.req_fun0;
  assign sel_chain = bus.req_chain[grant];
  assign sel_b     = (sel_chain && CHAIN_EN) ? last_result_q[3:0] : sel_b_raw;

  // Next-state and handshake decode for IDLE -> EXEC -> RESP.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    ready      = 2'b00;
    case (state)
      IDLE: begin
        ready = grant ? 2'b10 : 2'b01;
        if (bus.req_valid[grant]) begin
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC:    state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; a synchronous reset abandons any operation in flight.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Operand capture at acceptance.
  // NOTE: these are deliberately not reset; they are only read in EXEC,
  // which is always preceded by a load.
  always_ff @(posedge clock) begin
    if (accept) begin
      op_a   <= sel_a;
      op_b   <= sel_b;
      op_fun <= sel_fun;
      op_id  <= grant;
    end
  end

  alu8_core u_alu (
    .a   (op_a),
    .b   (op_b),
    .fun (op_fun),
    .out (alu_out)
  );

  // Priority pointer and result registers visible to the outside.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ptr           <= 1'b0;
      rsp_data_q    <= 8'h00;
      rsp_id_q      <= 1'b0;
      last_result_q <= 8'h00;
    end else begin
      if (accept) ptr <= ~grant;
      if (state == EXEC) begin
        rsp_data_q    <= alu_out;
        last_result_q <= alu_out;
        rsp_id_q      <= op_id;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = (state != IDLE);
  assign last_result   = last_result_q;

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Directed bench for alu_arbiter_ctrl. A second instance built with
// CHAIN_EN=0 follows the same stimulus so chain gating can be compared.
module tb_alu_arbiter_ctrl;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       busy, busy_nc;
  logic [7:0] last_result, last_result_nc;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  alu_arbiter_ctrl_if bus ();
  alu_arbiter_ctrl_if bus_nc ();

  assign bus_nc.req_valid = bus.req_valid;
  assign bus_nc.req_a0    = bus.req_a0;
  assign bus_nc.req_b0    = bus.req_b0;
  assign bus_nc.req_fun0  = bus.req_fun0;
  assign bus_nc.req_a1    = bus.req_a1;
  assign bus_nc.req_b1    = bus.req_b1;
  assign bus_nc.req_fun1  = bus.req_fun1;
  assign bus_nc.req_chain = bus.req_chain;
  assign bus_nc.rsp_ready = bus.rsp_ready;

  alu_arbiter_ctrl #(.CHAIN_EN(1'b1)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .busy        (busy),
    .last_result (last_result)
  );

  alu_arbiter_ctrl #(.CHAIN_EN(1'b0)) dut_nc (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus_nc),
    .busy        (busy_nc),
    .last_result (last_result_nc)
  );

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic clear_inputs();
    bus.req_valid = 2'b00;
    bus.req_a0    = 4'h0;
    bus.req_b0    = 4'h0;
    bus.req_fun0  = 3'd0;
    bus.req_a1    = 4'h0;
    bus.req_b1    = 4'h0;
    bus.req_fun1  = 3'd0;
    bus.req_chain = 2'b00;
    bus.rsp_ready = 1'b0;
  endtask

  // One complete single-port transaction with rsp_ready held high.
  task automatic do_op(input logic port, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] fun, input logic chain,
                       output logic [7:0] data, output logic [7:0] data_nc,
                       output logic id, output bit ok);
    int n;
    ok      = 1'b1;
    data    = 8'h00;
    data_nc = 8'h00;
    id      = 1'b0;
    if (port) begin
      bus.req_a1 = a; bus.req_b1 = b; bus.req_fun1 = fun;
    end else begin
      bus.req_a0 = a; bus.req_b0 = b; bus.req_fun0 = fun;
    end
    bus.req_chain       = 2'b00;
    bus.req_chain[port] = chain;
    bus.req_valid       = 2'b00;
    bus.req_valid[port] = 1'b1;
    bus.rsp_ready       = 1'b1;
    #1;
    n = 0;
    while (!bus.req_ready[port] && n < 10) begin tick(); n++; end
    if (!bus.req_ready[port]) ok = 1'b0;
    tick();
    bus.req_valid = 2'b00;
    bus.req_chain = 2'b00;
    n = 0;
    while (!bus.rsp_valid && n < 10) begin tick(); n++; end
    if (!bus.rsp_valid) ok = 1'b0;
    data    = bus.rsp_data;
    data_nc = bus_nc.rsp_data;
    id      = bus.rsp_id;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    total++; if (bus.rsp_data !== 8'h00) begin bad++; $display("FAIL reset_rsp_data: got %h expected 00", bus.rsp_data); end
    total++; if (bus.rsp_id !== 1'b0) begin bad++; $display("FAIL reset_rsp_id: got %b expected 0", bus.rsp_id); end
    total++; if (last_result !== 8'h00) begin bad++; $display("FAIL reset_last_result: got %h expected 00", last_result); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_alternate();
    int         n_rsp;
    logic       exp_id;
    logic [7:0] exp_data;
    bus.req_a0 = 4'd2; bus.req_b0 = 4'd3; bus.req_fun0 = 3'd7;
    bus.req_a1 = 4'd1; bus.req_b1 = 4'h9; bus.req_fun1 = 3'd5;
    bus.req_chain = 2'b00;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    n_rsp = 0;
    for (int c = 0; c < 40 && n_rsp < 4; c++) begin
      tick();
      if (bus.rsp_valid) begin
        exp_id   = n_rsp[0];
        exp_data = exp_id ? 8'h12 : 8'h06;
        total++; if (bus.rsp_id !== exp_id) begin bad++; $display("FAIL alt_id[%0d]: got %b expected %b", n_rsp, bus.rsp_id, exp_id); end
        total++; if (bus.rsp_data !== exp_data) begin bad++; $display("FAIL alt_data[%0d]: got %h expected %h", n_rsp, bus.rsp_data, exp_data); end
        n_rsp++;
        if (n_rsp == 4) bus.req_valid = 2'b00;
      end
    end
    total++; if (n_rsp != 4) begin bad++; $display("FAIL alt_count: got %0d expected 4", n_rsp); end
    bus.req_valid = 2'b00;
    tick();
  endtask

  task automatic test_basic();
    bus.req_a0 = 4'd5; bus.req_b0 = 4'd3; bus.req_fun0 = 3'd1;
    bus.req_chain = 2'b00;
    bus.req_valid = 2'b01;
    bus.rsp_ready = 1'b1;
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL basic_ready: got %b expected 01", bus.req_ready); end
    tick();
    bus.req_valid = 2'b00;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL basic_exec_valid: got %b expected 0", bus.rsp_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_exec_busy: got %b expected 1", busy); end
    tick();
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL basic_rsp_valid: got %b expected 1", bus.rsp_valid); end
    total++; if (bus.rsp_data !== 8'h08) begin bad++; $display("FAIL basic_rsp_data: got %h expected 08", bus.rsp_data); end
    total++; if (bus.rsp_id !== 1'b0) begin bad++; $display("FAIL basic_rsp_id: got %b expected 0", bus.rsp_id); end
    tick();
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop: got %b expected 0", bus.rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_backpressure();
    // Pointer is 1 here, so port 1 wins the contention.
    bus.req_a1 = 4'd2; bus.req_b1 = 4'hC; bus.req_fun1 = 3'd6;
    bus.req_a0 = 4'd0; bus.req_b0 = 4'd0; bus.req_fun0 = 3'd0;
    bus.req_chain = 2'b00;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b0;
    #1;
    total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL bp_grant: got %b expected 10", bus.req_ready); end
    tick();
    bus.req_valid = 2'b01;
    tick();
    for (int c = 0; c < 5; c++) begin
      total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, bus.rsp_valid); end
      total++; if (bus.rsp_data !== 8'h03) begin bad++; $display("FAIL bp_data[%0d]: got %h expected 03", c, bus.rsp_data); end
      total++; if (bus.rsp_id !== 1'b1) begin bad++; $display("FAIL bp_id[%0d]: got %b expected 1", c, bus.rsp_id); end
      total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL bp_req_ready[%0d]: got %b expected 00", c, bus.req_ready); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy[%0d]: got %b expected 1", c, busy); end
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %b expected 0", bus.rsp_valid); end
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL bp_release_ready: got %b expected 01", bus.req_ready); end
    total++; if (last_result !== 8'h03) begin bad++; $display("FAIL bp_last_result: got %h expected 03", last_result); end
    // Withdraw port 0 before it is accepted: nothing should start.
    bus.req_valid = 2'b00;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_dropped_busy: got %b expected 0", busy); end
    total++; if (last_result !== 8'h03) begin bad++; $display("FAIL bp_dropped_last: got %h expected 03", last_result); end
  endtask

  task automatic test_edge_arith();
    logic [2:0] tf [8] = '{3'd0, 3'd5, 3'd4, 3'd3, 3'd6, 3'd1, 3'd2, 3'd4};
    logic [3:0] ta [8] = '{4'hF, 4'h7, 4'h0, 4'hA, 4'h3, 4'hF, 4'h9, 4'h0};
    logic [3:0] tb [8] = '{4'h0, 4'hF, 4'h0, 4'h6, 4'h8, 4'h1, 4'h9, 4'h4};
    logic [7:0] te [8] = '{8'h10, 8'h80, 8'h00, 8'hEC, 8'h01, 8'h10, 8'h12, 8'h01};
    logic [7:0] data, data_nc;
    logic       id, port;
    bit         ok;
    for (int i = 0; i < 8; i++) begin
      port = i[0];
      do_op(port, ta[i], tb[i], tf[i], 1'b0, data, data_nc, id, ok);
      total++; if (!ok) begin bad++; $display("FAIL arith_timeout[%0d]: got no handshake expected response", i); end
      total++; if (data !== te[i]) begin bad++; $display("FAIL arith_data[%0d] fun=%0d: got %h expected %h", i, tf[i], data, te[i]); end
      total++; if (id !== port) begin bad++; $display("FAIL arith_id[%0d]: got %b expected %b", i, id, port); end
    end
  endtask

  task automatic test_chain();
    logic [7:0] data, data_nc;
    logic       id;
    bit         ok;
    do_op(1'b1, 4'hF, 4'hF, 3'd1, 1'b0, data, data_nc, id, ok);
    total++; if (!ok) begin bad++; $display("FAIL chain1_timeout: got no handshake expected response"); end
    total++; if (data !== 8'h1E) begin bad++; $display("FAIL chain1_data: got %h expected 1e", data); end
    total++; if (data_nc !== 8'h1E) begin bad++; $display("FAIL chain1_data_nc: got %h expected 1e", data_nc); end
    do_op(1'b1, 4'h1, 4'h5, 3'd2, 1'b1, data, data_nc, id, ok);
    total++; if (!ok) begin bad++; $display("FAIL chain2_timeout: got no handshake expected response"); end
    total++; if (data !== 8'h0F) begin bad++; $display("FAIL chain2_data: got %h expected 0f", data); end
    total++; if (data_nc !== 8'h06) begin bad++; $display("FAIL chain2_data_nc: got %h expected 06", data_nc); end
    total++; if (id !== 1'b1) begin bad++; $display("FAIL chain2_id: got %b expected 1", id); end
  endtask

  task automatic test_reset_mid();
    int n;
    // Port 0 op leaves the pointer at 1 and parks in RESP.
    bus.req_a0 = 4'd1; bus.req_b0 = 4'd1; bus.req_fun0 = 3'd2;
    bus.req_chain = 2'b00;
    bus.req_valid = 2'b01;
    bus.rsp_ready = 1'b0;
    tick();
    bus.req_valid = 2'b00;
    tick();
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %b expected 1", bus.rsp_valid); end
    reset_n = 1'b0;
    tick();
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_rsp_valid: got %b expected 0", bus.rsp_valid); end
    total++; if (last_result !== 8'h00) begin bad++; $display("FAIL mid_last_result: got %h expected 00", last_result); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b expected 0", busy); end
    reset_n = 1'b1;
    // Contention after reset: port 0 first; its chain reads B=0.
    bus.req_a0 = 4'd3; bus.req_b0 = 4'd9; bus.req_fun0 = 3'd2;
    bus.req_a1 = 4'd1; bus.req_b1 = 4'd1; bus.req_fun1 = 3'd0;
    bus.req_chain = 2'b01;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    n = 0;
    tick();
    while (!bus.rsp_valid && n < 10) begin tick(); n++; end
    bus.req_valid = 2'b00;
    bus.req_chain = 2'b00;
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL mid_post_timeout: got %b expected 1", bus.rsp_valid); end
    total++; if (bus.rsp_id !== 1'b0) begin bad++; $display("FAIL mid_post_id: got %b expected 0", bus.rsp_id); end
    total++; if (bus.rsp_data !== 8'h03) begin bad++; $display("FAIL mid_post_data: got %h expected 03", bus.rsp_data); end
    total++; if (bus_nc.rsp_data !== 8'h0C) begin bad++; $display("FAIL mid_post_data_nc: got %h expected 0c", bus_nc.rsp_data); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_alternate();
    test_basic();
    test_backpressure();
    test_edge_arith();
    test_chain();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter_ctrl.md
# alu_arbiter_ctrl

Shares one 8-function, 4-bit-operand ALU datapath between two requesters (port 0 and port 1) with valid/ready handshakes and round-robin fairness. It captures the granted request's operands, runs the ALU for one cycle and registers the 8-bit result. It returns the result on a response channel tagged with the requester ID. It sits between the board-level input sources (switch bank, pattern generator) and the result consumer (hex display driver / result register), and replaces direct wiring of operands to the ALU.

## Interface
- CHAIN_EN, 1: when 1, the per-request chain bit substitutes B with last_result[3:0]; when 0, the chain bits are ignored.
- clock  in  1  system clock, all state updates on rising edge
- reset_n  in  1  reset, synchronous, active-low
- req_valid  in  2  per-port request valid
- req_ready  out  2  per-port request ready
- req_a0, req_b0  in  4 each  port 0 operands
- req_fun0  in  3  port 0 function select
- req_a1, req_b1  in  4 each  port 1 operands
- req_fun1  in  3  port 1 function select
- req_chain  in  2  per-port chain select (B := last_result[3:0])
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  8  registered ALU result
- rsp_id  out  1  port that issued the response
- busy  out  1  high in any state other than IDLE
- last_result  out  8  most recently completed result

## Operation
- Functions (fun): 0 A+1; 1 A+B via ripple adder (carry in bit 4); 2 A+B via `+`, zero-extended; 3 {A|B, A^B}; 4 OR-reduction of {A,B} in bit 0; 5 B<<A (8-bit result, bits shifted past bit 7 lost); 6 B>>A; 7 A*B (unsigned, 8-bit). All results are unsigned and 8 bits wide, with upper bits zero-filled.
- FSM states: IDLE, EXEC, RESP.
- IDLE, arbitration rules:
  - If only one port is valid, it wins.
  - If both ports are valid, the port equal to the priority pointer wins.
  - req_ready[i] = (state==IDLE) & grant==i, where grant is combinational from req_valid.
  - On acceptance, latch A, B (or last_result[3:0] if chain & CHAIN_EN), fun and id. Set the pointer to the other port. Go to EXEC.
- EXEC: register the ALU output into rsp_data and last_result, set rsp_id, go to RESP.
- RESP: hold rsp_valid=1 with stable rsp_data/rsp_id until rsp_ready. On rsp_valid&rsp_ready, go to IDLE.
- Boundary rules:
  - Requests arriving in EXEC/RESP are not accepted (req_ready=0). The requester holds valid.
  - Chain on the first operation after reset uses B=0.
  - A simultaneous request on both ports alternates strictly: 0,1,0,1,…
  - Deasserting req_valid while not ready drops that request; no state is affected.

## Timing
- Reset values: state IDLE, pointer 0, rsp_valid 0, rsp_data 0, rsp_id 0, last_result 0, busy 0. req_ready follows the IDLE rule (it may be high during reset only if the combinational rule yields it; acceptance is suppressed while reset_n=0).
- Request accepted at edge k → rsp_valid=1 after edge k+1. Earliest next acceptance is at the edge after the response handshake, so there is a minimum of 3 cycles per op.
- rsp_ready may be high before rsp_valid. The handshake completes at the first edge where both are high.
- A reset asserted mid-operation (EXEC or RESP) abandons the operation: no response is issued, last_result returns to 0, and the pointer returns to 0.

## Structure
- A shared package holds:
  - fun encodings as named constants (FUN_INC, FUN_ADD_RC, FUN_ADD, FUN_ORXOR, FUN_ORRED, FUN_SHL, FUN_SHR, FUN_MUL);
  - the state encoding constants (IDLE, EXEC, RESP).
- One sub-module, alu8_core: purely combinational, inputs A[3:0], B[3:0], fun[2:0], output out[7:0]. It internally reuses the 4-bit ripple adder. The arbitration FSM and registers stay in alu_arbiter_ctrl.

## Test plan
- Reset, then port 0: A=5, B=3, fun=1, rsp_ready=1 → rsp_data=0x08, rsp_id=0, rsp_valid high for exactly 1 cycle, 2 cycles after acceptance.
- Both ports valid continuously (p0: A=2,B=3,fun=7; p1: A=1,B=0x9,fun=5) → responses alternate id 0 (0x06), id 1 (0x12), id 0, id 1.
- Chain: p1 fun=1 A=0xF B=0xF → 0x1E; then p1 fun=2 A=1 chain=1 → B=0xE, result 0x0F; with CHAIN_EN=0 the same inputs give 1+req_b1.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid → rsp_data/rsp_id stable, req_ready=2'b00, busy=1 throughout.
- Edge arithmetic: fun=0 A=0xF → 0x10; fun=5 A=7 B=0xF → 0x80; fun=4 A=0 B=0 → 0x00; fun=3 A=0xA B=0x6 → 0xEC.
- Reset asserted in RESP → next cycle rsp_valid=0, last_result=0, and a subsequent two-port contention grants port 0 first.
